ppdu_framer: RTL and testbench

Bit-serial PPDU transmit framer; the transmit-side counterpart of the bit-serial demodulator. It accepts a PSDU length and a stream of payload bytes, then emits one bit per handshake: SHR (64-bit preamble plus 16-bit SFD), PHR (PSDU length in bits), PSDU, and a CRC-16 FCS. It sits between the MAC byte interface and the modulator bit interface.

---
 rtl/ppdu_pkg.sv | 28 ++
 rtl/crc16_serial.sv | 24 ++
 rtl/ppdu_framer.sv | 194 +++++++++++++++++++
 tb/tb_ppdu_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppdu_pkg.sv
// Shared constants, state encoding and the CCITT CRC step for the PPDU
// transmit framer and its receive-side FCS checker.
package ppdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHR,
    PHR,
    PSDU,
    FCS
  } state_t;

  localparam logic [63:0] SHR_PREAMBLE = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [15:0] SHR_SFD      = 16'hF398;

  localparam int SHR_BITS = 80;
  localparam int PHR_BITS = 16;
  localparam int FCS_BITS = 16;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  // One serial step of the CRC-16 as seen from the transmitted bit order.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((b ^ crc[15]) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 (poly 0x1021, init 0x0000); shared between the
// transmit framer and the receive-side FCS checker.
module crc16_serial
  import ppdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, data);
    end
  end

endmodule

// File: rtl/ppdu_framer.sv
// Bit-serial PPDU transmit framer: SHR, PHR, PSDU and CRC-16 FCS emitted
// one bit per valid/ready handshake from a byte-wide payload stream.
module ppdu_framer
  import ppdu_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [79:0] SHR_SEQ = {SHR_SFD, SHR_PREAMBLE};

  state_t           state;
  logic [6:0]       bit_cnt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fetch_cnt;
  logic [LEN_W-1:0] load_cnt;
  logic [7:0]       buf_data;
  logic             buf_full;
  logic [15:0]      sreg;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [15:0]      phr;
  logic             xfer;
  logic             accept;
  logic             start;
  logic             take;

  assign xfer     = data_out_valid && data_out_ready;
  assign start    = (state == IDLE) && tx_start;
  assign in_ready = !buf_full && (fetch_cnt < len) && (state == PHR || state == PSDU);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign phr      = 16'({len, 3'b000});
  assign crc_next = crc16_step(crc, data_out);

  crc16_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (xfer && (state == PSDU)),
    .data (data_out),
    .crc  (crc)
  );

  // The shift register pulls a byte from the buffer at a byte boundary or
  // while stalled waiting for one.
  always_comb begin
    take = 1'b0;
    if (buf_full) begin
      case (state)
        PHR:     take = xfer && (bit_cnt == 7'(PHR_BITS - 1)) && (len != '0);
        PSDU:    take = !data_out_valid || (xfer && (bit_cnt == 7'd7) && (load_cnt != len));
        default: take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_data  <= '0;
      buf_full  <= 1'b0;
      fetch_cnt <= '0;
    end else if (start) begin
      buf_full  <= 1'b0;
      fetch_cnt <= '0;
    end else if (accept) begin
      buf_data  <= in_data;
      buf_full  <= 1'b1;
      fetch_cnt <= fetch_cnt + 1'b1;
    end else if (take) begin
      buf_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      len            <= '0;
      load_cnt       <= '0;
      sreg           <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            len            <= tx_len;
            load_cnt       <= '0;
            bit_cnt        <= '0;
            data_out       <= SHR_SEQ[0];
            data_out_valid <= 1'b1;
            state          <= SHR;
          end
        end
        SHR: begin
          if (xfer) begin
            if (bit_cnt == 7'(SHR_BITS - 1)) begin
              state    <= PHR;
              bit_cnt  <= '0;
              data_out <= phr[0];
              sreg     <= {1'b0, phr[15:1]};
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              data_out <= SHR_SEQ[bit_cnt + 7'd1];
            end
          end
        end
        PHR: begin
          if (xfer) begin
            if (bit_cnt == 7'(PHR_BITS - 1)) begin
              bit_cnt <= '0;
              if (len == '0) begin
                state    <= FCS;
                data_out <= crc[15];
                sreg     <= {crc[14:0], 1'b0};
              end else begin
                state <= PSDU;
                if (take) begin
                  data_out <= buf_data[0];
                  sreg     <= {9'h000, buf_data[7:1]};
                  load_cnt <= load_cnt + 1'b1;
                end else begin
                  data_out_valid <= 1'b0;
                end
              end
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              data_out <= sreg[0];
              sreg     <= {1'b0, sreg[15:1]};
            end
          end
        end
        PSDU: begin
          if (take) begin
            bit_cnt        <= '0;
            data_out       <= buf_data[0];
            data_out_valid <= 1'b1;
            sreg           <= {9'h000, buf_data[7:1]};
            load_cnt       <= load_cnt + 1'b1;
          end else if (xfer) begin
            if (bit_cnt == 7'd7) begin
              if (load_cnt == len) begin
                // The last PSDU bit is folded in this cycle, so the FCS
                // must start from the post-update CRC value.
                state    <= FCS;
                bit_cnt  <= '0;
                data_out <= crc_next[15];
                sreg     <= {crc_next[14:0], 1'b0};
              end else begin
                data_out_valid <= 1'b0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              data_out <= sreg[0];
              sreg     <= {1'b0, sreg[15:1]};
            end
          end
        end
        FCS: begin
          if (xfer) begin
            if (bit_cnt == 7'(FCS_BITS - 1)) begin
              state          <= IDLE;
              bit_cnt        <= '0;
              data_out       <= 1'b0;
              data_out_valid <= 1'b0;
              done           <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              data_out <= sreg[15];
              sreg     <= {sreg[14:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppdu_framer.sv
// Self-checking bench for ppdu_framer: a frame-level bit model feeds an
// expected-bit queue that a per-cycle compare process consumes.
module tb_ppdu_framer;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tx_start = 1'b0;
  logic [LEN_W-1:0] tx_len = '0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             data_out;
  logic             data_out_valid;
  logic             data_out_ready = 1'b1;
  logic             busy;
  logic             done;

  ppdu_framer #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_start       (tx_start),
    .tx_len         (tx_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  logic       exp_q[$];
  logic [7:0] payload[$];
  logic [7:0] byte_q[$];
  int         frame_bits = 0;
  int         done_count = 0;
  int         ready_mode = 0;
  logic       expect_done = 1'b0;
  logic       prev_wait = 1'b0;
  logic       prev_bit = 1'b0;
  logic       ready_seen = 1'b0;
  logic       hold = 1'b0;
  int         nbits;
  logic [15:0] fcs;
  int         d0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_crc(input int len);
    logic [15:0] c = 16'h0000;
    logic fb;
    for (int k = 0; k < len; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = payload[k][b] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Whole-frame bit list straight from the frame layout.
  task automatic build_expected(input int len, output int n, output logic [15:0] f);
    logic [15:0] sfd = 16'hF398;
    logic [15:0] phr_word;
    phr_word = 16'(len * 8);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(i % 2 == 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(sfd[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(phr_word[i]);
    for (int k = 0; k < len; k++)
      for (int b = 0; b < 8; b++) exp_q.push_back(payload[k][b]);
    f = model_crc(len);
    for (int i = 15; i >= 0; i--) exp_q.push_back(f[i]);
    n = exp_q.size();
  endtask

  // Per-cycle compare against the expected-bit queue.
  always @(negedge clk) begin
    if (!rst) begin
      expect_done = 1'b0;
      prev_wait   = 1'b0;
    end else begin
      if (in_ready) ready_seen = 1'b1;
      if (expect_done) begin
        check_output("done_pulse", done, 1);
        check_output("done_busy", busy, 0);
        check_output("done_valid", data_out_valid, 0);
        expect_done = 1'b0;
      end else if (done) begin
        check_output("spurious_done", done, 0);
      end
      if (done) done_count++;
      if (prev_wait) begin
        check_output("hold_valid", data_out_valid, 1);
        check_output("hold_data", data_out, prev_bit);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("extra_bit", data_out_valid, 0);
        end else begin
          check_output($sformatf("bit%0d", frame_bits), data_out, exp_q.pop_front());
          frame_bits++;
          if (exp_q.size() == 0) expect_done = 1'b1;
        end
      end
      prev_wait = data_out_valid && !data_out_ready;
      prev_bit  = data_out;
    end
  end

  initial begin : byte_driver
    logic hs;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs && byte_q.size() > 0) void'(byte_q.pop_front());
      #1;
      in_valid = (byte_q.size() > 0) && !hold;
      in_data  = in_valid ? byte_q[0] : 8'h00;
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      data_out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic apply_stimulus(input int len, input int mode, input int hold_at,
                                input int poke_at, input int rst_at);
    int n;
    int start_dones;
    int stall_cycles = 0;
    int hold_left = 0;
    logic [15:0] f;
    logic held = 1'b0;
    logic poked = 1'b0;
    logic reset_hit = 1'b0;
    build_expected(len, n, f);
    byte_q      = payload;
    frame_bits  = 0;
    ready_mode  = mode;
    ready_seen  = 1'b0;
    start_dones = done_count;
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_len   = LEN_W'(len);
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check_output("start_busy", busy, 1);
    check_output("start_valid", data_out_valid, 1);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (done_count != start_dones) break;
      if (hold_at >= 0 && frame_bits >= hold_at && !held) begin
        hold = 1'b1; held = 1'b1; hold_left = 20;
      end
      if (hold) begin
        if (!data_out_valid) stall_cycles++;
        hold_left--;
        if (hold_left == 0) hold = 1'b0;
      end
      if (poke_at >= 0 && frame_bits >= poke_at && !poked) begin
        tx_start = 1'b1; tx_len = LEN_W'(5); poked = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      if (rst_at >= 0 && frame_bits >= rst_at) begin
        rst = 1'b0; reset_hit = 1'b1;
        break;
      end
    end
    tx_start   = 1'b0;
    hold       = 1'b0;
    ready_mode = 0;
    if (!reset_hit) begin
      check_output("frame_done", done_count - start_dones, 1);
      check_output("frame_bits", frame_bits, n);
      check_output("frame_left", exp_q.size(), 0);
      if (hold_at >= 0) check_output("stall_seen", stall_cycles > 0, 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_data"}, data_out, 0);
    check_output({tag, "_valid"}, data_out_valid, 0);
    check_output({tag, "_in_ready"}, in_ready, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b1;

    // Hand-computed anchors for the model itself.
    payload = '{8'h01};
    build_expected(1, nbits, fcs);
    check_output("model_len1_bits", nbits, 120);
    check_output("model_len1_fcs", fcs, 16'h9188);
    check_output("model_pre_bit1", exp_q[1], 1);
    check_output("model_sfd_bit3", exp_q[67], 1);
    check_output("model_phr_bit3", exp_q[83], 1);
    check_output("model_psdu_bit0", exp_q[96], 1);
    payload.delete();
    build_expected(0, nbits, fcs);
    check_output("model_len0_bits", nbits, 112);
    check_output("model_len0_fcs", fcs, 16'h0000);
    exp_q.delete();

    payload = '{8'h01};
    apply_stimulus(1, 0, -1, -1, -1);

    payload.delete();
    apply_stimulus(0, 0, -1, -1, -1);
    check_output("len0_in_ready", ready_seen, 0);

    payload = '{8'h00, 8'h00};
    apply_stimulus(2, 1, -1, -1, -1);

    payload = '{8'h3C, 8'hA5, 8'hF0};
    apply_stimulus(3, 0, 100, -1, -1);

    payload = '{8'h5A, 8'hC3};
    apply_stimulus(2, 0, -1, -1, 100);
    @(negedge clk);
    check_idle_outputs("midreset");
    byte_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    payload = '{8'h01};
    apply_stimulus(1, 0, -1, -1, -1);

    payload = '{8'h81, 8'h7E};
    d0 = done_count;
    apply_stimulus(2, 0, -1, 120, -1);
    repeat (30) @(negedge clk);
    check_output("poke_one_done", done_count - d0, 1);
    check_output("poke_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
